ss_op_sequencer: RTL and testbench

Sequences Zicfiss-style shadow-stack operations between the issue stage and the LSU memory port. It owns the architectural shadow-stack pointer (SSP) register and accepts one operation at a time. It generates the push/pop memory access at the SSP-derived address and commits the SSP update only when the memory response returns. It sits beside the load/store unit, feeds `ssp_o` to the CSR file, and takes software SSP writes from the CSR file.

---
 rtl/ss_op_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ss_op_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_op_sequencer.sv
// Shadow-stack operation sequencer: owns SSP, issues push/pop accesses to the LSU port and
// commits the SSP update only once the memory response has returned.
module ss_op_sequencer #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned BYTES = XLEN / 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_data_i,
    input  logic            flush_i,
    input  logic            csr_we_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] ssp_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_data_o,
    output logic            resp_fault_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MEM   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [2:0] OP_PUSH   = 3'd0;
    localparam logic [2:0] OP_POP    = 3'd1;
    localparam logic [2:0] OP_POPCHK = 3'd2;
    localparam logic [2:0] OP_RR     = 3'd3;

    localparam logic [XLEN-1:0] STEP       = XLEN'(BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(BYTES - 1);

    logic [2:0]      r_state, w_state_d;
    logic [2:0]      r_op, w_op_d;
    logic [XLEN-1:0] r_data, w_data_d;
    logic [XLEN-1:0] r_ssp, w_ssp_d;
    logic [XLEN-1:0] r_addr, w_addr_d;
    logic            r_we, w_we_d;
    logic [XLEN-1:0] r_resp_data, w_resp_data_d;
    logic            r_fault, w_fault_d;

    always_comb begin
        w_state_d     = r_state;
        w_op_d        = r_op;
        w_data_d      = r_data;
        w_ssp_d       = r_ssp;
        w_addr_d      = r_addr;
        w_we_d        = r_we;
        w_resp_data_d = r_resp_data;
        w_fault_d     = r_fault;

        case (r_state)
            ST_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    w_op_d    = req_op_i;
                    w_data_d  = req_data_i;
                    w_fault_d = 1'b0;
                    case (req_op_i)
                        OP_PUSH: begin
                            w_addr_d  = r_ssp - STEP;
                            w_we_d    = 1'b1;
                            w_state_d = ST_MEM;
                        end
                        OP_POP, OP_POPCHK: begin
                            w_addr_d  = r_ssp;
                            w_we_d    = 1'b0;
                            w_state_d = ST_MEM;
                        end
                        OP_RR: begin
                            w_resp_data_d = r_ssp;
                            w_state_d     = ST_RESP;
                        end
                        default: begin
                            w_fault_d = 1'b1;
                            w_state_d = ST_RESP;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                // A granted access must still have its response drained after a flush.
                if (mem_gnt_i) begin
                    w_state_d = flush_i ? ST_DRAIN : ST_WAIT;
                end else if (flush_i) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    if (flush_i) begin
                        w_state_d = ST_IDLE;
                    end else begin
                        w_state_d = ST_RESP;
                        case (r_op)
                            OP_PUSH: w_ssp_d = r_ssp - STEP;
                            OP_POP: begin
                                w_ssp_d       = r_ssp + STEP;
                                w_resp_data_d = mem_rdata_i;
                            end
                            default: begin
                                w_resp_data_d = mem_rdata_i;
                                if (mem_rdata_i == r_data) begin
                                    w_ssp_d = r_ssp + STEP;
                                end else begin
                                    w_fault_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end else if (flush_i) begin
                    w_state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid_i) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_RESP: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase

        // Software write overrides a same-edge commit.
        if (csr_we_i) begin
            w_ssp_d = csr_wdata_i & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_op        <= 3'd0;
            r_data      <= '0;
            r_ssp       <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_resp_data <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_op        <= w_op_d;
            r_data      <= w_data_d;
            r_ssp       <= w_ssp_d;
            r_addr      <= w_addr_d;
            r_we        <= w_we_d;
            r_resp_data <= w_resp_data_d;
            r_fault     <= w_fault_d;
        end
    end

    assign req_ready_o  = (r_state == ST_IDLE) && !flush_i;
    assign ssp_o        = r_ssp;
    assign mem_req_o    = (r_state == ST_MEM);
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_data;
    assign resp_valid_o = (r_state == ST_RESP) && !flush_i;
    assign resp_data_o  = r_resp_data;
    assign resp_fault_o = resp_valid_o && r_fault;

endmodule

// File: tb/tb_ss_op_sequencer.sv
// Self-checking bench for ss_op_sequencer: directed plan steps plus random operations
// checked against an arithmetic SSP model.
module tb_ss_op_sequencer;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned BYTES = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [2:0]      req_op_i = 3'd0;
    logic [XLEN-1:0] req_data_i = '0;
    logic            flush_i = 1'b0;
    logic            csr_we_i = 1'b0;
    logic [XLEN-1:0] csr_wdata_i = '0;
    logic [XLEN-1:0] ssp_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_gnt_i = 1'b0;
    logic            mem_rvalid_i = 1'b0;
    logic [XLEN-1:0] mem_rdata_i = '0;
    logic            resp_valid_o;
    logic [XLEN-1:0] resp_data_o;
    logic            resp_fault_o;

    ss_op_sequencer #(.XLEN(XLEN), .BYTES(BYTES)) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_data_i   (req_data_i),
        .flush_i      (flush_i),
        .csr_we_i     (csr_we_i),
        .csr_wdata_i  (csr_wdata_i),
        .ssp_o        (ssp_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_fault_o (resp_fault_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_ssp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled 3 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic csr_write(input logic [63:0] val);
        csr_we_i    = 1'b1;
        csr_wdata_i = val;
        tick();
        csr_we_i = 1'b0;
        m_ssp    = val & ~64'(BYTES - 1);
        #3 chk("csr_ssp", ssp_o, m_ssp);
    endtask

    task automatic mem_op(input logic [2:0] op, input logic [63:0] data, input int gdly,
                          input int rdly, input logic [63:0] rdata, input bit csr_on_rv,
                          input logic [63:0] csrv);
        logic [63:0] exp_addr;
        logic        exp_fault;
        exp_addr    = (op == 3'd0) ? m_ssp - 64'(BYTES) : m_ssp;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_data_i  = data;
        #3 chk("accept_ready", req_ready_o, 1'b1);
        tick();
        req_valid_i = 1'b0;
        req_data_i  = rnd64();
        for (int g = 0; g <= gdly; g++) begin
            mem_gnt_i    = (g == gdly);
            mem_rvalid_i = 1'($urandom_range(0, 1));
            #3;
            chk("mem_req", mem_req_o, 1'b1);
            chk("mem_addr", mem_addr_o, exp_addr);
            chk("mem_we", mem_we_o, (op == 3'd0));
            if (op == 3'd0) chk("mem_wdata", mem_wdata_o, data);
            tick();
        end
        mem_gnt_i = 1'b0;
        for (int r = 0; r <= rdly; r++) begin
            mem_rvalid_i = (r == rdly);
            mem_rdata_i  = (r == rdly) ? rdata : rnd64();
            csr_we_i     = csr_on_rv && (r == rdly);
            csr_wdata_i  = csrv;
            #3;
            chk("wait_no_req", mem_req_o, 1'b0);
            chk("wait_no_resp", resp_valid_o, 1'b0);
            chk("wait_ssp", ssp_o, m_ssp);
            tick();
        end
        mem_rvalid_i = 1'b0;
        csr_we_i     = 1'b0;
        exp_fault    = 1'b0;
        case (op)
            3'd0: m_ssp = m_ssp - 64'(BYTES);
            3'd1: m_ssp = m_ssp + 64'(BYTES);
            default: begin
                if (rdata == data) m_ssp = m_ssp + 64'(BYTES);
                else exp_fault = 1'b1;
            end
        endcase
        if (csr_on_rv) m_ssp = csrv & ~64'(BYTES - 1);
        #3;
        chk("resp_valid", resp_valid_o, 1'b1);
        chk("resp_fault", resp_fault_o, exp_fault);
        chk("resp_ssp", ssp_o, m_ssp);
        if (op == 3'd1) chk("resp_data", resp_data_o, rdata);
        tick();
        #3;
        chk("resp_pulse_end", resp_valid_o, 1'b0);
        chk("ready_after", req_ready_o, 1'b1);
    endtask

    task automatic short_op(input logic [2:0] op);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_data_i  = rnd64();
        #3 chk("short_ready", req_ready_o, 1'b1);
        tick();
        req_valid_i = 1'b0;
        #3;
        chk("short_valid", resp_valid_o, 1'b1);
        chk("short_fault", resp_fault_o, (op > 3'd3));
        chk("short_no_req", mem_req_o, 1'b0);
        if (op == 3'd3) chk("rr_data", resp_data_o, m_ssp);
        tick();
        #3;
        chk("short_end", resp_valid_o, 1'b0);
        chk("short_ready_after", req_ready_o, 1'b1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [63:0] d;
        // Reset state
        #3;
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_ssp", ssp_o, 64'h0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 64'h0);
        chk("rst_mem_wdata", mem_wdata_o, 64'h0);
        chk("rst_resp_valid", resp_valid_o, 1'b0);
        chk("rst_resp_fault", resp_fault_o, 1'b0);
        chk("rst_resp_data", resp_data_o, 64'h0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Directed plan
        csr_write(64'h1007);
        chk("csr_align", ssp_o, 64'h1000);
        mem_op(3'd0, 64'hABCD, 0, 0, 64'h0, 1'b0, 64'h0);
        chk("push_ssp", ssp_o, 64'h0FF8);
        mem_op(3'd1, 64'h0, 0, 0, 64'h1234, 1'b0, 64'h0);
        chk("pop_ssp", ssp_o, 64'h1000);
        mem_op(3'd2, 64'h55, 0, 0, 64'h55, 1'b0, 64'h0);
        chk("popchk_ok_ssp", ssp_o, 64'h1008);
        csr_write(64'h1000);
        mem_op(3'd2, 64'h55, 1, 2, 64'h56, 1'b0, 64'h0);
        chk("popchk_bad_ssp", ssp_o, 64'h1000);
        csr_write(64'h0);
        mem_op(3'd0, 64'h77, 0, 0, 64'h0, 1'b0, 64'h0);
        chk("push_wrap", ssp_o, 64'hFFFF_FFFF_FFFF_FFF8);
        short_op(3'd3);
        mem_op(3'd0, 64'hDEAD_BEEF, 3, 1, 64'h0, 1'b0, 64'h0);

        // Flush in WAIT, response two cycles later
        req_valid_i = 1'b1; req_op_i = 3'd0; req_data_i = 64'h99;
        tick();
        req_valid_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #3 chk("drain_no_req", mem_req_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b1;
        #3 chk("drain_no_resp", resp_valid_o, 1'b0);
        chk("drain_not_ready", req_ready_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        #3;
        chk("drain_ready", req_ready_o, 1'b1);
        chk("drain_resp", resp_valid_o, 1'b0);
        chk("drain_ssp", ssp_o, m_ssp);

        // Flush in MEM before grant
        req_valid_i = 1'b1; req_op_i = 3'd1;
        tick();
        req_valid_i = 1'b0; flush_i = 1'b1;
        #3 chk("memflush_req", mem_req_o, 1'b1);
        tick();
        flush_i = 1'b0;
        #3;
        chk("memflush_idle", req_ready_o, 1'b1);
        chk("memflush_no_req", mem_req_o, 1'b0);
        chk("memflush_ssp", ssp_o, m_ssp);

        // Flush in RESP suppresses the pulse; flush in IDLE blocks accept
        req_valid_i = 1'b1; req_op_i = 3'd3;
        tick();
        req_valid_i = 1'b0; flush_i = 1'b1;
        #3 chk("respflush_valid", resp_valid_o, 1'b0);
        req_valid_i = 1'b1;
        tick();
        #3 chk("idleflush_ready", req_ready_o, 1'b0);
        tick();
        req_valid_i = 1'b0; flush_i = 1'b0;
        #3;
        chk("idleflush_no_op", resp_valid_o, 1'b0);
        chk("idleflush_no_req", mem_req_o, 1'b0);

        // POP with same-edge CSR write, then reserved op
        csr_write(64'h1000);
        mem_op(3'd1, 64'h0, 0, 1, 64'hCAFE, 1'b1, 64'h2000);
        chk("csr_wins", ssp_o, 64'h2000);
        short_op(3'd5);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            d  = rnd64();
            if ($urandom_range(0, 7) == 0) csr_write(rnd64());
            if (op < 3'd3) begin
                mem_op(op, d, $urandom_range(0, 3), $urandom_range(0, 3),
                       ($urandom_range(0, 1) != 0) ? d : rnd64(),
                       ($urandom_range(0, 7) == 0), rnd64());
            end else begin
                short_op(op);
            end
        end

        // Reset mid-operation; the stale response must be ignored
        csr_write(64'h4000);
        req_valid_i = 1'b1; req_op_i = 3'd1;
        tick();
        req_valid_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst_ni = 1'b0;
        m_ssp  = '0;
        #1;
        chk("midrst_ssp", ssp_o, m_ssp);
        chk("midrst_ready", req_ready_o, 1'b1);
        tick();
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1;
        tick();
        mem_rvalid_i = 1'b0;
        #3;
        chk("midrst_no_resp", resp_valid_o, 1'b0);
        chk("midrst_ssp_after", ssp_o, m_ssp);
        short_op(3'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
